// File: rtl/wdog_pkg.sv
// Shared types and default timing constants for the watchdog feeder.
package wdog_pkg;

  localparam int DEF_CNT_W       = 26;
  localparam int DEF_WIN_MIN     = 1000000;
  localparam int DEF_WIN_MAX     = 40000000;
  localparam int DEF_BOOT_PERIOD = 25000000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_CLOSED = 2'b01,
    ST_OPEN   = 2'b10,
    ST_FAULT  = 2'b11
  } wdog_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE  = 2'b00,
    CAUSE_EARLY = 2'b01,
    CAUSE_LATE  = 2'b10
  } wdog_cause_e;

endpackage

// File: rtl/wdog_window_counter.sv
// Saturating elapsed-cycle counter; exposes only window compare flags.
module wdog_window_counter
  import wdog_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int WIN_MIN   = DEF_WIN_MIN,
  parameter int WIN_MAX   = DEF_WIN_MAX,
  parameter int BOOT_TERM = DEF_BOOT_PERIOD - 1
) (
  input  logic sys_clk_i,
  input  logic sys_rst_n_i,
  input  logic clear,
  output logic ge_min,
  output logic eq_max,
  output logic boot_hit
);

  logic [CNT_W-1:0] cnt_r;

  // Elapsed-cycle count: clear wins, otherwise count up and stick at all-ones.
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (cnt_r != {CNT_W{1'b1}}) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign ge_min   = (cnt_r >= CNT_W'(WIN_MIN));
  assign eq_max   = (cnt_r == CNT_W'(WIN_MAX));
  assign boot_hit = (cnt_r == CNT_W'(BOOT_TERM));

endmodule

// File: rtl/watchdog_feeder.sv
// Windowed heartbeat generator for the board watchdog.
// Define WDOG_FEEDER_BOOT_EN to toggle the heartbeat autonomously while disabled.
module watchdog_feeder
  import wdog_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int WIN_MIN     = DEF_WIN_MIN,
  parameter int WIN_MAX     = DEF_WIN_MAX,
  parameter int BOOT_PERIOD = DEF_BOOT_PERIOD
) (
  input  logic       sys_clk_i,
  input  logic       sys_rst_n_i,
  input  logic       enable_i,
  input  logic       kick_i,
  output logic       watchdog_o,
  output logic       kick_ack_o,
  output logic       fault_o,
  output logic [1:0] fault_cause_o,
  output logic [1:0] state_o
);

`ifdef WDOG_FEEDER_BOOT_EN
  localparam bit BOOT_EN = 1'b1;
`else
  localparam bit BOOT_EN = 1'b0;
`endif

  wdog_state_e state_r, state_nxt_s;
  wdog_cause_e cause_r, cause_nxt_s;
  logic        wd_r, ack_r, fault_r;
  logic        toggle_s, ack_s, clr_s, fault_nxt_s;
  logic        ge_min_s, eq_max_s, boot_hit_s;

  wdog_window_counter #(
    .CNT_W    (CNT_W),
    .WIN_MIN  (WIN_MIN),
    .WIN_MAX  (WIN_MAX),
    .BOOT_TERM(BOOT_PERIOD - 1)
  ) u_counter (
    .sys_clk_i  (sys_clk_i),
    .sys_rst_n_i(sys_rst_n_i),
    .clear      (clr_s),
    .ge_min     (ge_min_s),
    .eq_max     (eq_max_s),
    .boot_hit   (boot_hit_s)
  );

  // State register and registered outputs.
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      state_r <= ST_IDLE;
      cause_r <= CAUSE_NONE;
      wd_r    <= 1'b0;
      ack_r   <= 1'b0;
      fault_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cause_r <= cause_nxt_s;
      wd_r    <= wd_r ^ toggle_s;
      ack_r   <= ack_s;
      fault_r <= fault_nxt_s;
    end
  end

  // Next-state, counter clear and output decisions.
  always_comb begin
    state_nxt_s = state_r;
    cause_nxt_s = cause_r;
    fault_nxt_s = fault_r;
    toggle_s    = 1'b0;
    ack_s       = 1'b0;
    clr_s       = 1'b0;
    if (!enable_i) begin
      // Disable always wins; in IDLE the counter only runs for boot toggling.
      state_nxt_s = ST_IDLE;
      cause_nxt_s = CAUSE_NONE;
      fault_nxt_s = 1'b0;
      toggle_s    = (state_r == ST_IDLE) && BOOT_EN && boot_hit_s;
      clr_s       = (state_r != ST_IDLE) || !BOOT_EN || boot_hit_s;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nxt_s = ST_CLOSED;
          toggle_s    = 1'b1;
          clr_s       = 1'b1;
        end
        ST_CLOSED: begin
          if (eq_max_s) begin
            state_nxt_s = ST_FAULT;
            cause_nxt_s = CAUSE_LATE;
            fault_nxt_s = 1'b1;
          end else if (kick_i && ge_min_s) begin
            ack_s    = 1'b1;
            toggle_s = 1'b1;
            clr_s    = 1'b1;
          end else if (kick_i) begin
            state_nxt_s = ST_FAULT;
            cause_nxt_s = CAUSE_EARLY;
            fault_nxt_s = 1'b1;
          end else if (ge_min_s) begin
            state_nxt_s = ST_OPEN;
          end else begin
            state_nxt_s = ST_CLOSED;
          end
        end
        ST_OPEN: begin
          if (eq_max_s) begin
            state_nxt_s = ST_FAULT;
            cause_nxt_s = CAUSE_LATE;
            fault_nxt_s = 1'b1;
          end else if (kick_i) begin
            state_nxt_s = ST_CLOSED;
            ack_s       = 1'b1;
            toggle_s    = 1'b1;
            clr_s       = 1'b1;
          end else begin
            state_nxt_s = ST_OPEN;
          end
        end
        ST_FAULT: begin
          state_nxt_s = ST_FAULT;
        end
        default: begin
          state_nxt_s = ST_FAULT;
          fault_nxt_s = 1'b1;
        end
      endcase
    end
  end

  assign watchdog_o    = wd_r;
  assign kick_ack_o    = ack_r;
  assign fault_o       = fault_r;
  assign fault_cause_o = cause_r;
  assign state_o       = state_r;

endmodule

// File: tb/tb_watchdog_feeder.sv
// Randomized scoreboard bench for watchdog_feeder against a window-rule model.
module tb_watchdog_feeder;

  localparam int WMIN  = 4;
  localparam int WMAX  = 16;
  localparam int BOOTP = 8;
`ifdef WDOG_FEEDER_BOOT_EN
  localparam bit BOOT = 1'b1;
`else
  localparam bit BOOT = 1'b0;
`endif

  typedef struct packed {
    logic       wd;
    logic       ack;
    logic       fault;
    logic [1:0] cause;
    logic [1:0] st;
  } exp_t;

  logic       clk, rst_n, en, kick;
  logic       watchdog, ack, fault;
  logic [1:0] cause, st;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t mon_exp, mon_got;

  // Reference model: mode 0 = disabled, 1 = feeding, 2 = faulted.
  int       m_mode, m_el, m_idle;
  bit       m_hb, m_ack, m_fault;
  bit [1:0] m_cause;

  watchdog_feeder #(
    .CNT_W(26), .WIN_MIN(WMIN), .WIN_MAX(WMAX), .BOOT_PERIOD(BOOTP)
  ) dut (
    .sys_clk_i(clk), .sys_rst_n_i(rst_n), .enable_i(en), .kick_i(kick),
    .watchdog_o(watchdog), .kick_ack_o(ack), .fault_o(fault),
    .fault_cause_o(cause), .state_o(st)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t model_out();
    exp_t e;
    e.wd    = m_hb;
    e.ack   = m_ack;
    e.fault = m_fault;
    e.cause = m_cause;
    if (m_mode == 0)         e.st = 2'b00;
    else if (m_mode == 2)    e.st = 2'b11;
    else if (m_el <= WMIN)   e.st = 2'b01;
    else                     e.st = 2'b10;
    return e;
  endfunction

  task automatic go_fault(input bit [1:0] c);
    m_mode  = 2;
    m_fault = 1'b1;
    m_cause = c;
  endtask

  task automatic model_step(input bit r, input bit e, input bit k);
    m_ack = 1'b0;
    if (!r) begin
      m_mode = 0; m_el = 0; m_idle = 0;
      m_hb = 1'b0; m_fault = 1'b0; m_cause = 2'b00;
    end else if (!e) begin
      if (m_mode != 0) begin
        m_mode = 0; m_idle = 0; m_fault = 1'b0; m_cause = 2'b00;
      end else if (BOOT) begin
        m_idle++;
        if (m_idle == BOOTP) begin
          m_hb   = ~m_hb;
          m_idle = 0;
        end
      end
    end else if (m_mode == 0) begin
      m_mode = 1; m_el = 0; m_hb = ~m_hb;
    end else if (m_mode == 1) begin
      if (k && m_el >= WMIN && m_el < WMAX) begin
        m_ack = 1'b1; m_hb = ~m_hb; m_el = 0;
      end else if (k && m_el < WMIN) begin
        go_fault(2'b01);
      end else if (m_el >= WMAX) begin
        go_fault(2'b10);
      end else begin
        m_el++;
      end
    end
  endtask

  // One cycle: drive inputs on the falling edge and queue the post-edge expectation.
  task automatic step(input bit r, input bit e, input bit k);
    @(negedge clk);
    rst_n = r;
    en    = e;
    kick  = k;
    model_step(r, e, k);
    exp_q.push_back(model_out());
    if (!r) begin
      #1;
      checks++;
      if ({watchdog, ack, fault, cause, st} !== 7'b0) begin
        errors++;
        $display("FAIL async_reset t=%0t got=%b exp=%b", $time,
                 {watchdog, ack, fault, cause, st}, 7'b0);
      end
    end
  endtask

  // Advance with enable high and no kick until the model's elapsed count is n.
  task automatic run_to(input int n);
    int guard;
    guard = 0;
    while (!(m_mode == 1 && m_el == n) && guard < 64) begin
      step(1'b1, 1'b1, 1'b0);
      guard++;
    end
    if (guard >= 64) begin
      checks++;
      errors++;
      $display("FAIL run_to target=%0d got_el=%0d mode=%0d", n, m_el, m_mode);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare each against the queue head.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_got = {watchdog, ack, fault, cause, st};
      checks++;
      if (mon_got !== mon_exp) begin
        errors++;
        $display("FAIL outputs t=%0t got wd=%b ack=%b fault=%b cause=%b st=%b exp wd=%b ack=%b fault=%b cause=%b st=%b",
                 $time, mon_got.wd, mon_got.ack, mon_got.fault, mon_got.cause, mon_got.st,
                 mon_exp.wd, mon_exp.ack, mon_exp.fault, mon_exp.cause, mon_exp.st);
      end
    end
  end

  initial begin
    int kick_div;
    rst_n = 1'b0; en = 1'b0; kick = 1'b0;
    m_mode = 0; m_el = 0; m_idle = 0;
    m_hb = 1'b0; m_ack = 1'b0; m_fault = 1'b0; m_cause = 2'b00;

    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    // Enable, then legal kicks at the window edge and mid-window.
    step(1'b1, 1'b1, 1'b0);
    run_to(WMIN);
    step(1'b1, 1'b1, 1'b1);
    run_to(10);
    step(1'b1, 1'b1, 1'b1);
    // Early kick faults; heartbeat must stay frozen under further kicks.
    run_to(2);
    step(1'b1, 1'b1, 1'b1);
    repeat (100) step(1'b1, 1'b1, 1'($urandom_range(0, 1)));
    repeat (3) step(1'b1, 1'b0, 1'b0);
    // Missing kick faults late.
    repeat (20) step(1'b1, 1'b1, 1'b0);
    repeat (2) step(1'b1, 1'b0, 1'b0);
    // Last legal cycle accepted, deadline cycle faults.
    step(1'b1, 1'b1, 1'b0);
    run_to(WMAX - 1);
    step(1'b1, 1'b1, 1'b1);
    run_to(WMAX);
    step(1'b1, 1'b1, 1'b1);
    repeat (3) step(1'b1, 1'b1, 1'b0);
    // Kick in the disabling cycle is ignored.
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    run_to(6);
    step(1'b1, 1'b0, 1'b1);
    // Asynchronous reset mid-window.
    step(1'b1, 1'b1, 1'b0);
    run_to(9);
    step(1'b0, 1'b1, 1'b0);
    repeat (12) step(1'b1, 1'b0, 1'b0);
    // Disabled idle: boot toggling only when the feature is built in.
    repeat (100) step(1'b1, 1'b0, 1'b0);

    // Randomized segments with varying kick density.
    for (int seg = 0; seg < 60; seg++) begin
      kick_div = (seg % 3 == 0) ? 3 : ((seg % 3 == 1) ? 8 : 40);
      for (int c = 0; c < 50; c++) begin
        if ($urandom_range(0, 499) == 0)
          step(1'b0, 1'b1, 1'b0);
        else
          step(1'b1, ($urandom_range(0, 59) != 0),
               ($urandom_range(0, kick_div - 1) == 0));
      end
    end

    step(1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/watchdog_feeder.md
Name: watchdog_feeder

Overview:
Drives the toggling heartbeat line consumed by the board watchdog. Software kicks arrive as single-cycle pulses. Each kick is checked against a min/max window measured from the previous accepted kick. A kick that is too early, or a missing kick, latches a fault and freezes the heartbeat so the downstream watchdog expires. Sits between the processor GPIO/register block and the watchdog input, on sys_clk_i.

Parameters:
CNT_W, 26, width of elapsed-cycle counter.
WIN_MIN, 1000000, earliest legal kick, in cycles after the previous accepted kick.
WIN_MAX, 40000000, deadline: elapsed == WIN_MAX with no kick -> fault. Must be < 50000000, the downstream watchdog count.
BOOT_PERIOD, 25000000, autonomous toggle period while disabled (optional feature only).

Ports:
sys_clk_i  in  1  system clock, single clock domain.
sys_rst_n_i  in  1  asynchronous active-low reset.
enable_i  in  1  level; 1 = windowed feeding active.
kick_i  in  1  single-cycle kick request from software.
watchdog_o  out  1  heartbeat level; each accepted kick toggles it.
kick_ack_o  out  1  one-cycle pulse: kick accepted.
fault_o  out  1  sticky fault flag.
fault_cause_o  out  2  00 none, 01 early, 10 late.
state_o  out  2  current FSM state, for status register.

Behaviour:
- Reset (async, sys_rst_n_i=0): state IDLE, counter 0, watchdog_o=0, kick_ack_o=0, fault_o=0, fault_cause_o=00.
- All outputs are registered. For kick_i sampled high at edge N, watchdog_o toggle and kick_ack_o appear after edge N (1-cycle latency).
- Counter: counts cycles since the last accepted kick (or since enable). Cleared to 0 on accept or entry to CLOSED. Saturates at 2^CNT_W-1, never wraps.
- States (encoding 00/01/10/11):
  - IDLE (00): counter held at 0. kick_i ignored, no ack. On enable_i=1 -> CLOSED: counter cleared and watchdog_o toggled once (implicit first kick, no ack).
  - CLOSED (01): counter < WIN_MIN. A kick here -> FAULT, cause 01, no toggle, no ack. When counter reaches WIN_MIN -> OPEN.
  - OPEN (10): kick -> ack, toggle, counter cleared, -> CLOSED. Counter reaching WIN_MAX with no kick -> FAULT, cause 10.
  - FAULT (11): watchdog_o frozen, fault_o=1, kicks ignored. Exit only via enable_i=0 -> IDLE, which clears fault_o and cause.
- Boundaries:
  - A kick in the same cycle the counter reaches WIN_MIN is accepted.
  - A kick at counter WIN_MAX-1 is accepted.
  - A kick in the cycle the counter reaches WIN_MAX: the fault wins.
- enable_i=0 in any state -> IDLE on the next edge. A kick in that cycle is ignored and watchdog_o is held.
- An asynchronous reset mid-window returns to IDLE immediately. Any partially counted window is discarded.

Optional Feature:
- Macro: WDOG_FEEDER_BOOT_EN.
- Defined: in IDLE, watchdog_o toggles autonomously every BOOT_PERIOD cycles, using the same counter cleared at each toggle, so the board survives boot before software enables feeding. FAULT still freezes the line.
- Undefined: IDLE holds watchdog_o constant, and the BOOT_PERIOD parameter is unused.

Decomposition:
- Package wdog_pkg: state encodings (IDLE/CLOSED/OPEN/FAULT), fault cause codes (NONE/EARLY/LATE), default WIN_MIN/WIN_MAX/CNT_W constants.
- One sub-module, wdog_window_counter: saturating CNT_W up-counter with synchronous clear. Outputs ge_min and eq_max compare flags, so the FSM sees only flags.

Test Plan (override WIN_MIN=4, WIN_MAX=16, BOOT_PERIOD=8):
1. Reset, then enable_i=1 -> watchdog_o toggles 0->1 one cycle later; state_o=01; fault_o=0.
2. Kick at counter 4 and again at counter 10 -> kick_ack_o pulses each time, watchdog_o toggles each time, state returns to 01.
3. Kick at counter 2 -> fault_o=1, cause=01, no ack, watchdog_o frozen for 100 cycles; enable_i=0 -> state 00, fault cleared.
4. No kick after enable -> at counter 16, fault_o=1, cause=10. A kick at counter 15 in a separate run is accepted; a kick at 16 faults.
5. Assert sys_rst_n_i=0 mid-OPEN at counter 9 -> all outputs 0 immediately; release -> IDLE, no toggle until enable.
6. With WDOG_FEEDER_BOOT_EN, enable_i=0 -> watchdog_o toggles every 8 cycles. Without it -> no toggle over 100 cycles.
